// File: rtl/clk_trig_decoder.sv
// Duty-cycle clock/trigger link receiver: oversamples clk_in on fastclk, locks onto a stable
// period and decodes one trigger bit per period. Optional majority glitch filter: CLK_TRIG_GLITCH_FILT_EN.
module clk_trig_decoder #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned MAX_PERIOD = 64,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             trig_out,
  output logic             trig_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned LcW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MAX_PERIOD + 1);
  localparam logic [CNT_W:0]   MinP       = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MaxP       = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [LcW-1:0]   LockLast   = LcW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e           state;
  logic             sync_meta, sync_out;
  logic             s, s_d, rise, rise_q, timeout;
  logic [CNT_W-1:0] pcnt, hcnt, p_meas, h_meas;
  logic [LcW-1:0]   lock_ctr;
  logic [CNT_W:0]   p_ext, h_ext, h_dbl;
  logic             period_ok, bit_dec;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= clk_in;
      sync_out  <= sync_meta;
    end
  end

`ifdef CLK_TRIG_GLITCH_FILT_EN
  logic tap1, tap2;

  // 2-of-3 vote over the last three synchronizer samples rejects single-cycle pulses
  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      tap1 <= 1'b0;
      tap2 <= 1'b0;
      s    <= 1'b0;
    end else begin
      tap1 <= sync_out;
      tap2 <= tap1;
      s    <= (sync_out & tap1) | (sync_out & tap2) | (tap1 & tap2);
    end
  end
`else
  assign s = sync_out;
`endif

  assign rise    = s & ~s_d;
  // Only the crossing cycle counts, so a long gap triggers loss-of-clock once
  assign timeout = (pcnt == TimeoutCnt) && !rise;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      s_d    <= 1'b0;
      pcnt   <= '0;
      hcnt   <= '0;
      rise_q <= 1'b0;
      p_meas <= '0;
      h_meas <= '0;
    end else begin
      s_d    <= s;
      rise_q <= rise;
      if (rise) begin
        p_meas <= pcnt;
        h_meas <= hcnt;
        pcnt   <= CntOne;
        hcnt   <= {{(CNT_W-1){1'b0}}, s};
      end else begin
        if (pcnt != CntMax) pcnt <= pcnt + CntOne;
        if (s && (hcnt != CntMax)) hcnt <= hcnt + CntOne;
      end
    end
  end

  always_comb begin
    p_ext     = {1'b0, p_meas};
    h_ext     = {1'b0, h_meas};
    h_dbl     = {h_meas, 1'b0};
    period_ok = (p_ext >= MinP) && (p_ext <= MaxP) && (h_ext != '0) &&
                (h_ext < p_ext) && (h_dbl != p_ext);
    bit_dec   = h_dbl < p_ext;
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state      <= StSearch;
      lock_ctr   <= '0;
      trig_out   <= 1'b0;
      trig_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      period     <= '0;
    end else begin
      trig_valid <= 1'b0;
      err        <= 1'b0;
      if (timeout) begin
        state    <= StSearch;
        locked   <= 1'b0;
        trig_out <= 1'b0;
        lock_ctr <= '0;
      end else if (rise_q) begin
        unique case (state)
          // First edge only opens a period; there is nothing to judge yet
          StSearch: state <= StAcquire;
          StAcquire: begin
            if (period_ok) begin
              lock_ctr <= lock_ctr + 1'b1;
              if (lock_ctr == LockLast) begin
                state  <= StLocked;
                locked <= 1'b1;
              end
            end else begin
              err      <= 1'b1;
              lock_ctr <= '0;
            end
          end
          StLocked: begin
            if (period_ok) begin
              trig_out   <= bit_dec;
              period     <= p_meas;
              trig_valid <= 1'b1;
            end else begin
              err      <= 1'b1;
              lock_ctr <= '0;
              locked   <= 1'b0;
              trig_out <= 1'b0;
              state    <= StAcquire;
            end
          end
          default: state <= StSearch;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_trig_decoder.sv
// Table-driven bench for clk_trig_decoder: each row drives one encoded period and checks the
// decision made at that period's opening edge, which judges the previous row's period.
module tb_clk_trig_decoder;

`ifdef CLK_TRIG_GLITCH_FILT_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  localparam int MAXP = 64;

  logic       fastclk, reset, clk_in;
  logic       trig_out, trig_valid, locked, err;
  logic [7:0] period;

  clk_trig_decoder #(
    .CNT_W     (8),
    .MIN_PERIOD(8),
    .MAX_PERIOD(64),
    .LOCK_CNT  (4)
  ) dut (
    .fastclk   (fastclk),
    .reset     (reset),
    .clk_in    (clk_in),
    .trig_out  (trig_out),
    .trig_valid(trig_valid),
    .locked    (locked),
    .err       (err),
    .period    (period)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  typedef struct {
    int high;
    int per;
    int e_err;
    int e_tv;
    int e_trig;
    int e_lock;
    int e_period;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Results of the most recent drive_period call
  int d_err, d_tv, d_trig, d_lock, d_period;
  int n_err, n_tv, fall;

  function automatic void add(int high, int per, int e_err, int e_tv, int e_trig, int e_lock,
                              int e_period);
    vec_t v;
    v.high = high; v.per = per; v.e_err = e_err; v.e_tv = e_tv;
    v.e_trig = e_trig; v.e_lock = e_lock; v.e_period = e_period;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one period starting on a negedge; glitch < 0 means no glitch
  task automatic drive_period(input int high, input int per, input int glitch);
    logic prev_lock;
    d_err = 0; d_tv = 0; d_trig = 0; d_lock = 0; d_period = 0;
    n_err = 0; n_tv = 0; fall = -1;
    prev_lock = locked;
    for (int n = 1; n <= per; n++) begin
      clk_in = ((n - 1) < high) || ((n - 1) == glitch);
      @(negedge fastclk);
      if (err) n_err++;
      if (trig_valid) n_tv++;
      if (prev_lock && !locked && fall < 0) fall = n;
      prev_lock = locked;
      if (n == LAT) begin
        d_err = int'(err); d_tv = int'(trig_valid); d_trig = int'(trig_out);
        d_lock = int'(locked); d_period = int'(period);
      end
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive_period(tbl[i].high, tbl[i].per, -1);
      check($sformatf("row%0d err", i), d_err, tbl[i].e_err);
      check($sformatf("row%0d trig_valid", i), d_tv, tbl[i].e_tv);
      check($sformatf("row%0d trig_out", i), d_trig, tbl[i].e_trig);
      check($sformatf("row%0d locked", i), d_lock, tbl[i].e_lock);
      check($sformatf("row%0d period", i), d_period, tbl[i].e_period);
      check($sformatf("row%0d stray_pulses", i), n_err + n_tv, d_err + d_tv);
    end
  endtask

  initial begin
    int bad;

    // Expected fields describe the decision on the previous row's period
    add(4, 16, 0, 0, 0, 0, 0);   // r0: first edge in SEARCH, no decode
    add(4, 16, 0, 0, 0, 0, 0);   // r1..r3: ACQUIRE counting
    add(4, 16, 0, 0, 0, 0, 0);
    add(4, 16, 0, 0, 0, 0, 0);
    add(4, 16, 0, 0, 0, 1, 0);   // r4: 4th valid period -> locked, no trig_valid
    add(12, 16, 0, 1, 1, 1, 16); // r5: judges 4/16 -> bit 1
    add(4, 16, 0, 1, 0, 1, 16);  // r6: judges 12/16 -> bit 0
    add(8, 16, 0, 1, 1, 1, 16);  // r7: judges 4/16
    add(4, 16, 1, 0, 0, 0, 16);  // r8: judges 8/16 (2H=P) -> err, unlock
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 20, 0, 0, 0, 1, 16);  // r12: relocked
    add(3, 8, 0, 1, 1, 1, 20);   // r13: judges 4/20
    add(40, 64, 0, 1, 1, 1, 8);  // r14: judges 3/8, MIN boundary
    add(2, 7, 0, 1, 0, 1, 64);   // r15: judges 40/64, MAX boundary, bit 0
    add(4, 16, 1, 0, 0, 0, 64);  // r16: judges 2/7 -> too short
    add(4, 65, 0, 0, 0, 0, 64);  // r17: judges 4/16 in ACQUIRE
    add(4, 16, 1, 0, 0, 0, 64);  // r18: judges P=65, rise beats timeout -> err
    add(4, 16, 0, 0, 0, 0, 64);
    add(4, 16, 0, 0, 0, 0, 64);
    add(4, 16, 0, 0, 0, 0, 64);
    add(4, 16, 0, 0, 0, 1, 64);  // r22: relocked
    add(4, 16, 0, 1, 1, 1, 16);  // r23
    // after loss of clock: restart from SEARCH
    add(4, 16, 0, 0, 0, 0, 16);  // r24
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 16, 0, 0, 0, 0, 16);
    add(4, 16, 0, 0, 0, 1, 16);  // r28
    add(4, 16, 0, 1, 1, 1, 16);  // r29

    // Reset held with clk_in toggling
    reset = 1'b0;
    clk_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fastclk);
      clk_in = ~clk_in;
      if (trig_out || trig_valid || locked || err || period != 8'd0) bad++;
    end
    check("reset_outputs_nonzero_cycles", bad, 0);
    clk_in = 1'b0;
    @(negedge fastclk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fastclk);
      if (trig_out || trig_valid || locked || err || period != 8'd0) bad++;
    end
    check("idle_after_reset", bad, 0);

    run_rows(0, 23);

    // Loss of clock: long low phase while locked
    drive_period(4, 74, -1);
    check("timeout open trig_valid", d_tv, 1);
    check("timeout open trig_out", d_trig, 1);
    check("timeout locked_fall_cycle", fall, LAT + MAXP);
    check("timeout err_pulses", n_err, 0);
    check("timeout locked_end", int'(locked), 0);
    check("timeout trig_out_end", int'(trig_out), 0);
    check("timeout period_held", int'(period), 16);

    run_rows(24, 29);

    // Single-cycle high glitch in the low phase
    drive_period(4, 16, 6);
    check("glitch trig_valid_pulses", n_tv, 1);
`ifdef CLK_TRIG_GLITCH_FILT_EN
    check("glitch err_pulses", n_err, 0);
    check("glitch locked_end", int'(locked), 1);
    check("glitch trig_out_end", int'(trig_out), 1);
    drive_period(4, 16, -1);
    check("post_glitch trig_valid", d_tv, 1);
    check("post_glitch trig_out", d_trig, 1);
    check("post_glitch err_pulses", n_err, 0);
`else
    check("glitch err_pulses", n_err, 1);
    check("glitch locked_end", int'(locked), 0);
    check("glitch trig_out_end", int'(trig_out), 0);
    drive_period(4, 16, -1);
    check("post_glitch trig_valid", d_tv, 0);
    check("post_glitch locked", d_lock, 0);
    check("post_glitch err_pulses", n_err, 0);
`endif

    // Asynchronous reset in the middle of a period
    clk_in = 1'b1;
    @(negedge fastclk);
    @(negedge fastclk);
    #2 reset = 1'b0;
    #1;
    check("midreset period", int'(period), 0);
    check("midreset flags", int'({trig_out, trig_valid, locked, err}), 0);
    clk_in = 1'b0;
    @(negedge fastclk);
    reset = 1'b1;
    @(negedge fastclk);
    drive_period(4, 16, -1);
    check("post_reset first_edge err", d_err, 0);
    drive_period(4, 16, -1);
    check("post_reset acquire locked", d_lock, 0);
    check("post_reset acquire pulses", n_err + n_tv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
